// File: rtl/microsequencer_pkg.sv
// Shared constants for the microprogrammed control unit: state width, sequencing
// and condition-select encodings, instruction fields and decode target states.
package control_pkg;

    localparam int STATE_W = 7;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t RESET_STATE = 7'd0;
    localparam state_t FETCH_STATE = 7'd1;

    // Next-state select field N
    typedef enum logic [2:0] {
        N_DECODE  = 3'b000,
        N_FETCH   = 3'b001,
        N_LITERAL = 3'b010,
        N_INC     = 3'b011,
        N_BRANCH  = 3'b100,
        N_WAIT    = 3'b101,
        N_HOLD    = 3'b110,
        N_ZERO    = 3'b111
    } nsel_t;

    // Condition select field S
    typedef enum logic [1:0] {
        S_MOC  = 2'b00,
        S_COND = 2'b01,
        S_ZERO = 2'b10,
        S_NONE = 2'b11
    } csel_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;

    localparam state_t ST_ADD  = 7'd6;
    localparam state_t ST_ADDU = 7'd17;
    localparam state_t ST_SUB  = 7'd18;
    localparam state_t ST_SUBU = 7'd19;
    localparam state_t ST_AND  = 7'd23;
    localparam state_t ST_OR   = 7'd25;
    localparam state_t ST_ADDI = 7'd16;
    localparam state_t ST_LW   = 7'd7;
    localparam state_t ST_SW   = 7'd13;
    localparam state_t ST_BEQ  = 7'd30;

endpackage

// File: rtl/microsequencer_if.sv
// Microstore-to-sequencer bundle: sequencing fields, status flags and instruction
// fields in one direction, the registered state index in the other.
interface microsequencer_if;
    import control_pkg::*;

    logic [2:0]         N;
    logic [1:0]         S;
    logic               Inv;
    logic [STATE_W-1:0] CR;
    logic               MOC;
    logic               Cond;
    logic               Zero;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [STATE_W-1:0] currentState;

    modport master (
        output N, S, Inv, CR, MOC, Cond, Zero, opcode, funct,
        input  currentState
    );

    modport slave (
        input  N, S, Inv, CR, MOC, Cond, Zero, opcode, funct,
        output currentState
    );

endinterface

// File: rtl/microsequencer_encoder.sv
// Combinational instruction decode: maps opcode/funct to the first microstate of
// that instruction's routine; anything unrecognised goes back to fetch.
module instruction_encoder
    import control_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_state
);

    always_comb begin
        o_state = FETCH_STATE;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_state = ST_ADD;
                    FN_ADDU: o_state = ST_ADDU;
                    FN_SUB:  o_state = ST_SUB;
                    FN_SUBU: o_state = ST_SUBU;
                    FN_AND:  o_state = ST_AND;
                    FN_OR:   o_state = ST_OR;
                    default: o_state = FETCH_STATE;
                endcase
            end
            OP_ADDI: o_state = ST_ADDI;
            OP_LW:   o_state = ST_LW;
            OP_SW:   o_state = ST_SW;
            OP_BEQ:  o_state = ST_BEQ;
            default: o_state = FETCH_STATE;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Next-state engine: chooses among decode, fetch, literal and increment under
// the microstore's sequencing fields and a selectable, invertible condition.
module microsequencer
    import control_pkg::*;
#(
    parameter int STATE_W = control_pkg::STATE_W
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.slave  bus
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_inc;
    state_t             w_enc;
    logic               w_sel;
    logic               w_cond;
    nsel_t              w_nsel;
    csel_t              w_csel;

    instruction_encoder u_encoder (
        .i_opcode (bus.opcode),
        .i_funct  (bus.funct),
        .o_state  (w_enc)
    );

    assign w_nsel = nsel_t'(bus.N);
    assign w_csel = csel_t'(bus.S);

    always_comb begin
        w_sel = 1'b0;
        case (w_csel)
            S_MOC:   w_sel = bus.MOC;
            S_COND:  w_sel = bus.Cond;
            S_ZERO:  w_sel = bus.Zero;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_cond = w_sel ^ bus.Inv;
    assign w_inc  = r_state + {{(STATE_W-1){1'b0}}, 1'b1};

    // Unknown or reserved selects fall through to the reset state
    always_comb begin
        w_next = RESET_STATE;
        case (w_nsel)
            N_DECODE:  w_next = w_enc;
            N_FETCH:   w_next = FETCH_STATE;
            N_LITERAL: w_next = bus.CR;
            N_INC:     w_next = w_inc;
            N_BRANCH:  w_next = w_cond ? bus.CR : w_inc;
            N_WAIT:    w_next = w_cond ? w_inc : r_state;
            N_HOLD:    w_next = w_cond ? r_state : bus.CR;
            default:   w_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    assign bus.currentState = r_state;

endmodule

// File: tb/tb_microsequencer.sv
// Directed scenarios plus randomized sequencing checked against a behavioural
// next-state model of the microsequencer.
module tb_microsequencer;

    logic clk = 1'b0;
    logic reset;

    microsequencer_if bus ();

    microsequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_state = 0;

    typedef struct {
        int op;
        int fn;
        int target;
    } dec_entry_t;

    dec_entry_t dec_tab [10];

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int decode_ref(input int op, input int fn);
        for (int k = 0; k < 10; k++) begin
            if (dec_tab[k].op == op && (dec_tab[k].fn < 0 || dec_tab[k].fn == fn))
                return dec_tab[k].target;
        end
        return 1;
    endfunction

    function automatic int next_ref(input int st, input int n, input int s, input int inv,
                                    input int cr, input int moc, input int cnd, input int zf,
                                    input int op, input int fn);
        int flags [4];
        int c;
        int inc;
        flags[0] = moc;
        flags[1] = cnd;
        flags[2] = zf;
        flags[3] = 0;
        c   = (flags[s] != inv) ? 1 : 0;
        inc = (st + 1) % 128;
        if (n == 0) return decode_ref(op, fn);
        if (n == 1) return 1;
        if (n == 2) return cr;
        if (n == 3) return inc;
        if (n == 4) return c ? cr : inc;
        if (n == 5) return c ? inc : st;
        if (n == 6) return c ? st : cr;
        return 0;
    endfunction

    task automatic drive(input logic [2:0] n, input logic [1:0] s, input logic inv,
                         input logic [6:0] cr, input logic moc, input logic cnd,
                         input logic zf, input logic [5:0] op, input logic [5:0] fn);
        bus.N      = n;
        bus.S      = s;
        bus.Inv    = inv;
        bus.CR     = cr;
        bus.MOC    = moc;
        bus.Cond   = cnd;
        bus.Zero   = zf;
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    task automatic tick_expect(input string tag, input int want);
        @(posedge clk);
        #1;
        check(tag, bus.currentState, 7'(want));
        exp_state = want;
    endtask

    task automatic load(input int st);
        drive(3'b010, 2'b11, 1'b0, 7'(st), 1'b0, 1'b0, 1'b0, 6'h3F, 6'h00);
        tick_expect("load", st);
    endtask

    initial begin
        dec_tab[0] = '{op: 'h00, fn: 'h20, target: 6};
        dec_tab[1] = '{op: 'h00, fn: 'h21, target: 17};
        dec_tab[2] = '{op: 'h00, fn: 'h22, target: 18};
        dec_tab[3] = '{op: 'h00, fn: 'h23, target: 19};
        dec_tab[4] = '{op: 'h00, fn: 'h24, target: 23};
        dec_tab[5] = '{op: 'h00, fn: 'h25, target: 25};
        dec_tab[6] = '{op: 'h08, fn: -1,   target: 16};
        dec_tab[7] = '{op: 'h23, fn: -1,   target: 7};
        dec_tab[8] = '{op: 'h2B, fn: -1,   target: 13};
        dec_tab[9] = '{op: 'h04, fn: -1,   target: 30};

        // Reset held with increment requested
        reset = 1'b1;
        drive(3'b011, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        for (int i = 0; i < 3; i++) tick_expect("reset_hold", 0);
        #3;
        reset = 1'b0;
        drive(3'b001, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        tick_expect("reset_release_fetch", 1);

        // Increment and wrap
        load(126);
        drive(3'b011, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        tick_expect("inc_127", 127);
        tick_expect("inc_wrap", 0);

        // MOC wait
        load(8);
        drive(3'b101, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        for (int i = 0; i < 4; i++) tick_expect("moc_wait", 8);
        bus.MOC = 1'b1;
        tick_expect("moc_done", 9);

        // Conditional branch on Cond
        load(4);
        drive(3'b100, 2'b01, 1'b0, 7'd30, 1'b0, 1'b1, 1'b0, 6'h00, 6'h00);
        tick_expect("br_taken", 30);
        load(4);
        drive(3'b100, 2'b01, 1'b0, 7'd30, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        tick_expect("br_not_taken", 5);
        load(4);
        drive(3'b100, 2'b01, 1'b1, 7'd30, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        tick_expect("br_inv_taken", 30);
        load(4);
        drive(3'b100, 2'b11, 1'b1, 7'd44, 1'b1, 1'b1, 1'b1, 6'h00, 6'h00);
        tick_expect("br_const_inv", 44);

        // Hold-on-condition using Zero
        load(10);
        drive(3'b110, 2'b10, 1'b0, 7'd20, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00);
        tick_expect("hold_zero", 10);
        bus.Zero = 1'b0;
        tick_expect("hold_release", 20);
        drive(3'b111, 2'b00, 1'b0, 7'd5, 1'b1, 1'b1, 1'b1, 6'h00, 6'h00);
        tick_expect("reserved_zero", 0);

        // Decode
        drive(3'b000, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h22);
        tick_expect("dec_sub", 18);
        drive(3'b000, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h11);
        tick_expect("dec_lw", 7);
        drive(3'b000, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h20);
        tick_expect("dec_illegal", 1);
        drive(3'b000, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h26);
        tick_expect("dec_bad_funct", 1);
        for (int k = 0; k < 10; k++) begin
            drive(3'b000, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'(dec_tab[k].op),
                  (dec_tab[k].fn < 0) ? 6'(k * 5) : 6'(dec_tab[k].fn));
            tick_expect("dec_table", dec_tab[k].target);
        end

        // Reset in the middle of a MOC wait
        load(8);
        drive(3'b101, 2'b00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00);
        tick_expect("mid_wait", 8);
        bus.MOC = 1'b1;
        reset   = 1'b1;
        tick_expect("mid_reset", 0);
        reset = 1'b0;
        bus.MOC = 1'b0;
        bus.N   = 3'b001;
        tick_expect("post_reset", 1);

        // Randomized sequencing against the reference model
        for (int i = 0; i < 600; i++) begin
            int n, s, inv, cr, moc, cnd, zf, op, fn, want, pick;
            logic rst_now;
            n   = $urandom_range(0, 7);
            s   = $urandom_range(0, 3);
            inv = $urandom_range(0, 1);
            cr  = $urandom_range(0, 127);
            moc = $urandom_range(0, 1);
            cnd = $urandom_range(0, 1);
            zf  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, 9);
                op = dec_tab[pick].op;
                fn = (dec_tab[pick].fn < 0) ? $urandom_range(0, 63) : dec_tab[pick].fn;
            end else begin
                op = $urandom_range(0, 63);
                fn = $urandom_range(0, 63);
            end
            if (n == 3 && $urandom_range(0, 3) == 0) begin
                load(125 + $urandom_range(0, 2));
            end
            rst_now = ($urandom_range(0, 49) == 0);
            reset = rst_now;
            drive(3'(n), 2'(s), 1'(inv), 7'(cr), 1'(moc), 1'(cnd), 1'(zf), 6'(op), 6'(fn));
            want = rst_now ? 0 : next_ref(exp_state, n, s, inv, cr, moc, cnd, zf, op, fn);
            tick_expect("random", want);
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
